// File: rtl/fp_round_stage.sv
// Rounding stage for unrounded FP results: applies the captured IEEE-754 rounding mode,
// saturates on overflow, raises fflags, and returns the result through a 2-entry valid/ready pipe.
package fp_pkg;
  typedef enum logic [1:0] {FP32 = 2'd0, FP64 = 2'd1, FP16 = 2'd2} fp_format_e;
  typedef enum logic [2:0] {RNE = 3'd0, RTZ = 3'd1, RDN = 3'd2, RUP = 3'd3, RMM = 3'd4} roundmode_e;

  function automatic int exp_bits(input fp_format_e f);
    case (f)
      FP64:    return 11;
      FP16:    return 5;
      default: return 8;
    endcase
  endfunction

  function automatic int man_bits(input fp_format_e f);
    case (f)
      FP64:    return 52;
      FP16:    return 10;
      default: return 23;
    endcase
  endfunction
endpackage

// urnd_i layout (MSB..LSB): {u_result, rs[1:0], round_en, invalid, exp_cout[1:0]}
module fp_round_stage
  import fp_pkg::*;
#(
  parameter fp_format_e FP_FORMAT = FP32,
  parameter int TAG_WIDTH = 4,
  localparam int EXP_WIDTH = exp_bits(FP_FORMAT),
  localparam int MANT_WIDTH = man_bits(FP_FORMAT),
  localparam int FP_WIDTH = 1 + EXP_WIDTH + MANT_WIDTH,
  localparam int URND_WIDTH = FP_WIDTH + 6
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [URND_WIDTH-1:0] urnd_i,
  input  logic [2:0]            rnd_i,
  input  logic [TAG_WIDTH-1:0]  tag_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [FP_WIDTH-1:0]   result_o,
  output logic [4:0]            fflags_o,
  output logic [TAG_WIDTH-1:0]  tag_o
);
  localparam int EM_WIDTH = EXP_WIDTH + MANT_WIDTH;

  logic                  s1_valid_q, s1_valid_d;
  logic [URND_WIDTH-1:0] s1_urnd_q;
  logic [2:0]            s1_rnd_q;
  logic [TAG_WIDTH-1:0]  s1_tag_q;
  logic                  s2_valid_q, s2_valid_d;
  logic [FP_WIDTH-1:0]   s2_result_q, s2_result_d;
  logic [4:0]            s2_fflags_q, s2_fflags_d;
  logic [TAG_WIDTH-1:0]  s2_tag_q;

  logic                  s2_adv, s1_adv, accept;
  logic                  sign, rbit, sticky, round_en, invalid, inc, ovf, nx, uf;
  logic [1:0]            exp_cout;
  logic [EM_WIDTH-1:0]   em, em_sum, em_inf, em_max;

  assign s2_adv      = ~s2_valid_q | out_ready_i;
  assign s1_adv      = s1_valid_q & s2_adv;
  assign in_ready_o  = flush_i | ~s1_valid_q | s2_adv;
  assign accept      = in_valid_i & in_ready_o & ~flush_i;
  assign out_valid_o = s2_valid_q;
  assign result_o    = s2_result_q;
  assign fflags_o    = s2_fflags_q;
  assign tag_o       = s2_tag_q;

  assign sign     = s1_urnd_q[URND_WIDTH-1];
  assign em       = s1_urnd_q[URND_WIDTH-2:6];
  assign rbit     = s1_urnd_q[5];
  assign sticky   = s1_urnd_q[4];
  assign round_en = s1_urnd_q[3];
  assign invalid  = s1_urnd_q[2];
  assign exp_cout = s1_urnd_q[1:0];
  assign em_inf   = {{EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
  assign em_max   = {{(EXP_WIDTH-1){1'b1}}, 1'b0, {MANT_WIDTH{1'b1}}};

  // Rounding increment, overflow saturation and flag generation from the S1 entry.
  always_comb begin
    inc         = 1'b0;
    s2_result_d = s1_urnd_q[URND_WIDTH-1 -: FP_WIDTH];
    s2_fflags_d = {invalid, 4'b0000};
    case (s1_rnd_q)
      RTZ:     inc = 1'b0;
      RDN:     inc = (rbit | sticky) & sign;
      RUP:     inc = (rbit | sticky) & ~sign;
      RMM:     inc = rbit;
      default: inc = rbit & (sticky | em[0]);
    endcase
    em_sum = em + {{(EM_WIDTH-1){1'b0}}, inc};
    ovf    = round_en & (exp_cout[1] | (&em_sum[EM_WIDTH-1:MANT_WIDTH]));
    nx     = (round_en & (rbit | sticky)) | ovf;
    uf     = round_en & ((em[EM_WIDTH-1:MANT_WIDTH] == {EXP_WIDTH{1'b0}}) | exp_cout[0]) & nx;
    if (round_en) begin
      s2_fflags_d = {invalid, 1'b0, ovf, uf, nx};
      if (ovf) begin
        case (s1_rnd_q)
          RTZ:     s2_result_d = {sign, em_max};
          RDN:     s2_result_d = {sign, sign ? em_inf : em_max};
          RUP:     s2_result_d = {sign, sign ? em_max : em_inf};
          default: s2_result_d = {sign, em_inf};
        endcase
      end else begin
        s2_result_d = {sign, em_sum};
      end
    end else begin
      s2_result_d = s1_urnd_q[URND_WIDTH-1 -: FP_WIDTH];
    end
  end

  // Valid-bit next state; flush wins over any accept or advance.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (flush_i) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      s1_valid_d = accept | (s1_valid_q & ~s1_adv);
      s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
    end
  end

  // S1 capture register.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      s1_valid_q <= 1'b0;
      s1_urnd_q  <= {URND_WIDTH{1'b0}};
      s1_rnd_q   <= 3'd0;
      s1_tag_q   <= {TAG_WIDTH{1'b0}};
    end else begin
      s1_valid_q <= s1_valid_d;
      if (accept) begin
        s1_urnd_q <= urnd_i;
        s1_rnd_q  <= rnd_i;
        s1_tag_q  <= tag_i;
      end
    end
  end

  // S2 output register; payload only moves when S1 advances so outputs hold under stall.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      s2_valid_q  <= 1'b0;
      s2_result_q <= {FP_WIDTH{1'b0}};
      s2_fflags_q <= 5'b00000;
      s2_tag_q    <= {TAG_WIDTH{1'b0}};
    end else begin
      s2_valid_q <= s2_valid_d;
      if (s1_adv && !flush_i) begin
        s2_result_q <= s2_result_d;
        s2_fflags_q <= s2_fflags_d;
        s2_tag_q    <= s1_tag_q;
      end
    end
  end
endmodule

// File: tb/tb_fp_round_stage.sv
// Scoreboard bench for fp_round_stage (FP32): directed rounding cases, backpressure,
// async reset and flush, followed by randomized traffic checked against a reference model.
module tb_fp_round_stage;
  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  ff;
    logic [3:0]  tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [37:0] urnd = 38'd0;
  logic [2:0]  rnd = 3'd0;
  logic [3:0]  tag = 4'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic [4:0]  fflags;
  logic [3:0]  tag_out;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];
  exp_t exp_cur;
  exp_t mon_e;

  fp_round_stage #(.TAG_WIDTH(4)) dut (
    .clk_i(clk), .reset_ni(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .urnd_i(urnd), .rnd_i(rnd), .tag_i(tag),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .result_o(result), .fflags_o(fflags), .tag_o(tag_out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference rounding model: returns {fflags, result}.
  function automatic logic [36:0] model(input logic [31:0] u, input logic [1:0] rs, input logic ren,
                                        input logic inv, input logic [1:0] ec, input logic [2:0] rm);
    logic        s, r, st, up, of, nx, uf;
    logic [31:0] mag, sat;
    s = u[31]; r = rs[1]; st = rs[0];
    if (!ren) return {inv, 4'b0000, u};
    case (rm)
      3'd1:    up = 1'b0;
      3'd2:    up = (r | st) & s;
      3'd3:    up = (r | st) & ~s;
      3'd4:    up = r;
      default: up = r & (st | u[0]);
    endcase
    mag = {1'b0, u[30:0]} + {31'd0, up};
    of  = ec[1] || (mag[30:23] == 8'hFF);
    nx  = r | st | of;
    uf  = ((u[30:23] == 8'h00) || ec[0]) && nx;
    if (of) begin
      if (rm == 3'd1 || (rm == 3'd2 && !s) || (rm == 3'd3 && s)) sat = {s, 31'h7F7FFFFF};
      else sat = {s, 31'h7F800000};
      return {inv, 1'b0, 1'b1, uf, 1'b1, sat};
    end
    return {inv, 1'b0, 1'b0, uf, nx, s, mag[30:0]};
  endfunction

  // Scoreboard: push on accepted input, pop and compare on consumed output.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check_eq("sb_underflow", 64'd1, 64'd0);
        end else begin
          mon_e = sb.pop_front();
          check_eq("result", {32'd0, result}, {32'd0, mon_e.res});
          check_eq("fflags", {59'd0, fflags}, {59'd0, mon_e.ff});
          check_eq("tag", {60'd0, tag_out}, {60'd0, mon_e.tag});
        end
      end
      if (flush) sb.delete();
      else if (in_valid && in_ready) sb.push_back(exp_cur);
    end
  end

  task automatic set_in(input logic [31:0] u, input logic [1:0] rs, input logic ren, input logic inv,
                        input logic [1:0] ec, input logic [2:0] rm, input logic [3:0] tg,
                        input logic [31:0] er, input logic [4:0] ef);
    urnd     = {u, rs, ren, inv, ec};
    rnd      = rm;
    tag      = tg;
    exp_cur  = '{res: er, ff: ef, tag: tg};
    in_valid = 1'b1;
  endtask

  // Offer one entry and return just after the edge that accepts it.
  task automatic send(input logic [31:0] u, input logic [1:0] rs, input logic ren, input logic inv,
                      input logic [1:0] ec, input logic [2:0] rm, input logic [3:0] tg,
                      input logic [31:0] er, input logic [4:0] ef);
    logic done;
    done = 1'b0;
    set_in(u, rs, ren, inv, ec, rm, tg, er, ef);
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        done = 1'b1;
      end else begin
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    end
    if (!done) check_eq("in_ready_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic send_model(input logic [31:0] u, input logic [1:0] rs, input logic ren, input logic inv,
                            input logic [1:0] ec, input logic [2:0] rm, input logic [3:0] tg);
    logic [36:0] m;
    m = model(u, rs, ren, inv, ec, rm);
    send(u, rs, ren, inv, ec, rm, tg, m[31:0], m[36:32]);
  endtask

  initial begin
    logic [31:0] ru;
    logic        ren;
    #12;
    check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check_eq("rst_result", {32'd0, result}, 64'd0);
    check_eq("rst_fflags", {59'd0, fflags}, 64'd0);
    check_eq("rst_tag", {60'd0, tag_out}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Latency: valid appears one edge after the accepting edge.
    out_ready = 1'b1;
    send(32'h3F800000, 2'b11, 1'b1, 1'b0, 2'b00, 3'd0, 4'd1, 32'h3F800001, 5'b00001);
    in_valid = 1'b0;
    check_eq("lat_accept_edge", {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;
    check_eq("lat_next_edge", {63'd0, out_valid}, 64'd1);

    // Ties, carry and overflow, invalid passthrough.
    send(32'h3F800000, 2'b10, 1'b1, 1'b0, 2'b00, 3'd0, 4'd2, 32'h3F800000, 5'b00001);
    send(32'h3F800001, 2'b10, 1'b1, 1'b0, 2'b00, 3'd0, 4'd3, 32'h3F800002, 5'b00001);
    send(32'h3FFFFFFF, 2'b11, 1'b1, 1'b0, 2'b00, 3'd3, 4'd4, 32'h40000000, 5'b00001);
    send(32'h7F7FFFFF, 2'b11, 1'b1, 1'b0, 2'b00, 3'd3, 4'd5, 32'h7F800000, 5'b00101);
    send(32'h7F7FFFFF, 2'b11, 1'b1, 1'b0, 2'b00, 3'd1, 4'd6, 32'h7F7FFFFF, 5'b00001);
    send(32'hFFC00000, 2'b00, 1'b0, 1'b1, 2'b00, 3'd2, 4'd7, 32'hFFC00000, 5'b10000);
    send(32'hFF7FFFFF, 2'b01, 1'b1, 1'b0, 2'b00, 3'd2, 4'd8, 32'hFF800000, 5'b00101);
    send(32'h00000001, 2'b01, 1'b1, 1'b0, 2'b00, 3'd0, 4'd9, 32'h00000001, 5'b00011);
    in_valid = 1'b0;
    repeat (3) @(posedge clk); #1;

    // Backpressure: two accepted, third stalls, then drain in order.
    out_ready = 1'b0;
    set_in(32'h3F800000, 2'b11, 1'b1, 1'b0, 2'b00, 3'd0, 4'd1, 32'h3F800001, 5'b00001);
    @(posedge clk); #1;
    set_in(32'h3F800002, 2'b11, 1'b1, 1'b0, 2'b00, 3'd1, 4'd2, 32'h3F800002, 5'b00001);
    @(posedge clk); #1;
    set_in(32'h3F800004, 2'b11, 1'b1, 1'b0, 2'b00, 3'd3, 4'd3, 32'h3F800005, 5'b00001);
    @(negedge clk);
    check_eq("bp_full_in_ready", {63'd0, in_ready}, 64'd0);
    check_eq("bp_hold_tag", {60'd0, tag_out}, 64'd1);
    @(posedge clk); #1;
    check_eq("bp_hold_result", {32'd0, result}, 64'h3F800001);
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_drain0", {59'd0, out_valid, tag_out}, {59'd0, 1'b1, 4'd1});
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("bp_drain1", {59'd0, out_valid, tag_out}, {59'd0, 1'b1, 4'd2});
    @(negedge clk);
    check_eq("bp_drain2", {59'd0, out_valid, tag_out}, {59'd0, 1'b1, 4'd3});
    @(posedge clk); #1;

    // Asynchronous reset mid-stream, between clock edges.
    out_ready = 1'b0;
    send(32'h40000000, 2'b11, 1'b1, 1'b0, 2'b00, 3'd0, 4'hA, 32'h40000001, 5'b00001);
    send(32'h40000002, 2'b11, 1'b1, 1'b0, 2'b00, 3'd0, 4'hB, 32'h40000003, 5'b00001);
    in_valid = 1'b0;
    #2;
    check_eq("pre_rst_valid", {63'd0, out_valid}, 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_valid", {63'd0, out_valid}, 64'd0);
    check_eq("async_rst_ready", {63'd0, in_ready}, 64'd1);
    check_eq("async_rst_result", {32'd0, result}, 64'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Flush while full, with a same-cycle offer that must be dropped.
    send(32'h40400000, 2'b11, 1'b1, 1'b0, 2'b00, 3'd0, 4'h1, 32'h40400001, 5'b00001);
    send(32'h40400002, 2'b11, 1'b1, 1'b0, 2'b00, 3'd0, 4'h2, 32'h40400003, 5'b00001);
    set_in(32'h40400004, 2'b11, 1'b1, 1'b0, 2'b00, 3'd0, 4'h3, 32'h40400005, 5'b00001);
    flush = 1'b1;
    @(negedge clk);
    check_eq("flush_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    check_eq("flush_out_valid", {63'd0, out_valid}, 64'd0);
    out_ready = 1'b1;
    send(32'h40800000, 2'b11, 1'b1, 1'b0, 2'b00, 3'd0, 4'hC, 32'h40800001, 5'b00001);
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("flush_no_stale", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    check_eq("flush_alone_valid", {59'd0, out_valid, tag_out}, {59'd0, 1'b1, 4'hC});
    @(negedge clk);
    check_eq("flush_alone_after", {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;

    // Randomized traffic with random backpressure and gaps.
    for (int i = 0; i < 200; i++) begin
      ru  = $urandom;
      ru[30:23] = 8'($urandom_range(0, 254));
      ren = ($urandom_range(0, 4) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      send_model(ru, 2'($urandom_range(0, 3)), ren, ren ? 1'b0 : 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b00,
                 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    check_eq("sb_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
